pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
Program-counter sequencer for the microcontroller fetch path. Holds the 8-bit PC and advances it with the PC+1 incrementer. Drives a req/ack fetch handshake to instruction memory and presents fetched instructions to the core with a valid/ready handshake. Applies jump (and optionally call/return) redirects supplied by the core when an instruction is consumed.

Parameters:
ADDR_W, 8, PC / instruction-memory address width; incrementer wraps modulo 2^ADDR_W
RESET_PC, 8'h00, PC value loaded on reset
STACK_DEPTH, 4, return-stack entries (used only with PC_CALL_STACK_EN)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active low
start  in  1  begin or resume fetching
halt  in  1  stop fetching
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address (= PC)
imem_ack  in  1  fetch complete, imem_data valid this cycle
imem_data  in  8  fetched instruction byte
instr_valid  out  1  instruction presented to core
instr  out  8  instruction byte
instr_pc  out  ADDR_W  address of instr
instr_ready  in  1  core consumes instr
jmp_valid  in  1  redirect to jmp_target, qualified by consume
jmp_target  in  ADDR_W  redirect/call target
call_valid  in  1  call, qualified by consume
ret_valid  in  1  return, qualified by consume
running  out  1  high in FETCH or HOLD
stk_err  out  1  sticky return-stack overflow/underflow

Behaviour:
- Reset is synchronous, active low, clocked on clk. On reset:
  - state=IDLE, PC=RESET_PC.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0, running=0, stk_err=0, stack emptied.
- Reset mid-transaction abandons any outstanding fetch. The memory side must tolerate a dropped req.
- States:
  - IDLE: wait for start.
  - FETCH: imem_req=1, imem_addr=PC held stable until imem_ack.
  - HOLD: instr_valid=1; instr and instr_pc held stable until instr_ready.
  - HALTED: idle, PC retained.
- Transitions:
  - IDLE -> FETCH on start & !halt.
  - FETCH -> HOLD on imem_ack: latch imem_data into instr and PC into instr_pc.
  - imem_ack in the first FETCH cycle is legal. Minimum latency start -> instr_valid is 2 cycles.
  - HOLD -> FETCH on instr_ready (consume). PC is updated at the same edge.
  - HALTED -> FETCH on start & !halt.
- PC update on consume, highest priority first:
  1. ret (macro only)
  2. call (macro only)
  3. jmp_valid: PC <= jmp_target
  4. otherwise PC <= PC+1, with 8'hFF -> 8'h00 wrap and no flag.
- Redirect inputs are ignored unless instr_valid & instr_ready.
- Halt:
  - In IDLE or HALTED: stay.
  - In FETCH: the outstanding request must complete. On imem_ack the data is discarded and the state goes to HALTED; PC is unchanged.
  - In HOLD: instr_valid drops next cycle and the state goes to HALTED; PC is unchanged, so the instruction is re-fetched on resume.
  - halt & instr_ready in the same HOLD cycle: halt wins, no consume.
- No back-to-back overlap: a new imem_req is issued at the earliest in the cycle after consume.
- start while running is ignored.

Optional Feature:
Macro PC_CALL_STACK_EN.
- Defined:
  - STACK_DEPTH-entry LIFO of ADDR_W-bit return addresses.
  - call on consume: push PC+1 (wrapped), PC <= jmp_target.
  - ret on consume: pop into PC.
  - Push when full: push dropped, jump still taken, stk_err=1.
  - Pop when empty: treated as sequential PC+1, stk_err=1.
  - stk_err is sticky; only reset clears it.
  - call & ret in the same consume: ret wins, no push.
- Undefined:
  - No stack storage.
  - call_valid behaves exactly as jmp_valid.
  - ret_valid is ignored (sequential).
  - stk_err tied 0.

Test Plan:
1. Reset, start pulse, memory acks 1 cycle after each req, instr_ready=1 -> imem_addr sequence 00,01,02,03; instr_pc matches; running=1.
2. PC=8'hFF consumed with no redirect -> next imem_addr=8'h00, no error.
3. Consume at PC=05 with jmp_valid=1, jmp_target=8'h40 -> next imem_addr=8'h40. jmp_valid asserted while instr_ready=0 -> ignored.
4. halt raised while waiting for ack at PC=10, ack 3 cycles later -> no instr_valid, state HALTED, running=0. start -> refetch from 10.
5. instr_ready held 0 for 5 cycles -> instr/instr_pc stable, imem_req=0. instr_ready=1 -> new req next cycle.
6. (PC_CALL_STACK_EN) call at 03 to 20, call at 21 to 30, ret -> 22, ret -> 04. Fifth nested call with depth 4 -> stk_err=1. Ret on empty stack -> PC+1, stk_err stays 1.

Source files
------------

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-path bundle: instruction-memory req/ack, instruction valid/ready toward the core,
// and the redirect (jump/call/return) qualifiers the core returns on consume.
interface pc_fetch_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [7:0]        imem_data;
    logic              instr_valid;
    logic [7:0]        instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              jmp_valid;
    logic [ADDR_W-1:0] jmp_target;
    logic              call_valid;
    logic              ret_valid;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_data, instr_ready, jmp_valid, jmp_target, call_valid, ret_valid
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_data, instr_ready, jmp_valid, jmp_target, call_valid, ret_valid
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program-counter fetch sequencer: one outstanding fetch, one held instruction, redirects on consume.
// Define PC_CALL_STACK_EN to add the call/return LIFO; otherwise call acts as jump and ret is ignored.
module pc_fetch_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                STACK_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 halt,
    pc_fetch_sequencer_if.master bus,
    output logic                 running,
    output logic                 stk_err
);
    // state   | meaning
    // IDLE    | out of reset, waiting for start
    // FETCH   | imem_req up, imem_addr = PC, waiting for ack
    // HOLD    | instruction presented, waiting for instr_ready
    // HALTED  | stopped by halt, PC retained for resume
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_next;
    logic [7:0]        instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              halt_pend;
    logic              consume;

    assign pc_inc        = pc + ADDR_W'(1);
    assign consume       = (state == S_HOLD) && bus.instr_ready && !halt;
    assign bus.imem_req  = (state == S_FETCH);
    assign bus.imem_addr = pc;
    assign bus.instr_valid = (state == S_HOLD);
    assign bus.instr     = instr_q;
    assign bus.instr_pc  = instr_pc_q;
    assign running       = (state == S_FETCH) || (state == S_HOLD);

`ifdef PC_CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [SP_W-1:0]   sp;
    logic              err_q;
    logic              push;
    logic              pop;
    logic              err_set;

    always_comb begin
        pc_next = pc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (bus.ret_valid) begin
            // Underflow falls through to sequential PC+1.
            if (sp == '0) begin
                err_set = 1'b1;
            end else begin
                pop     = 1'b1;
                pc_next = stack[IDX_W'(sp - 1'b1)];
            end
        end else if (bus.call_valid) begin
            pc_next = bus.jmp_target;
            if (sp == SP_FULL) err_set = 1'b1;
            else               push    = 1'b1;
        end else if (bus.jmp_valid) begin
            pc_next = bus.jmp_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp    <= '0;
            err_q <= 1'b0;
        end else if (consume) begin
            if (push)      sp <= sp + 1'b1;
            else if (pop)  sp <= sp - 1'b1;
            if (err_set)   err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (consume && push) stack[IDX_W'(sp)] <= pc_inc;
    end

    assign stk_err = err_q;
`else
    logic unused_ret;

    always_comb begin
        pc_next = pc_inc;
        if (bus.jmp_valid || bus.call_valid) pc_next = bus.jmp_target;
    end

    assign unused_ret = bus.ret_valid ^ (STACK_DEPTH == 0);
    assign stk_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            halt_pend  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start && !halt) state <= S_FETCH;
                end
                S_FETCH: begin
                    // A halt seen any time during the fetch discards the returning data.
                    if (bus.imem_ack) begin
                        halt_pend <= 1'b0;
                        if (halt || halt_pend) begin
                            state <= S_HALTED;
                        end else begin
                            state      <= S_HOLD;
                            instr_q    <= bus.imem_data;
                            instr_pc_q <= pc;
                        end
                    end else if (halt) begin
                        halt_pend <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (halt) begin
                        state <= S_HALTED;
                    end else if (bus.instr_ready) begin
                        state <= S_FETCH;
                        pc    <= pc_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench: expected fetch addresses are queued when a consume is driven and popped at each request.
module tb_pc_fetch_sequencer;
    logic clk;
    logic rst_n;
    logic start;
    logic halt;
    logic running;
    logic stk_err;

    pc_fetch_sequencer_if #(.ADDR_W(8)) bus ();

    pc_fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00), .STACK_DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .halt    (halt),
        .bus     (bus),
        .running (running),
        .stk_err (stk_err)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mstk  [$];
    bit         merr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_noise(input bit on);
        bus.jmp_valid  = on;
        bus.call_valid = on;
        bus.ret_valid  = on;
        bus.jmp_target = on ? 8'hEE : 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        halt  = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_data   = 8'h00;
        bus.instr_ready = 1'b0;
        set_noise(1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        mstk.delete();
        merr = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One fetch/present/consume round trip; the consume pushes the model's next PC.
    task automatic serve_one(input int ack_dly, input int rdy_dly, input bit j, input bit c,
                             input bit r, input logic [7:0] t, input bit hlt);
        int n;
        logic [7:0] exp, held, inc, nxt;
        n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL req_timeout: imem_req=%b required 1", bus.imem_req);
            return;
        end
        exp = exp_q.pop_front();
        checks++;
        if (bus.imem_addr !== exp) begin
            failures++;
            $display("FAIL imem_addr: got %h required %h", bus.imem_addr, exp);
        end
        set_noise(1'b1);
        repeat (ack_dly) @(negedge clk);
        set_noise(1'b0);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp) begin
            failures++;
            $display("FAIL req_hold: req=%b addr=%h required 1/%h", bus.imem_req, bus.imem_addr, exp);
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = exp ^ 8'h5A;
        @(negedge clk);
        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'h00;
        checks++;
        if (bus.instr_valid !== 1'b1 || running !== 1'b1) begin
            failures++;
            $display("FAIL present: instr_valid=%b running=%b required 1/1", bus.instr_valid, running);
        end
        checks++;
        if (bus.instr !== (exp ^ 8'h5A) || bus.instr_pc !== exp) begin
            failures++;
            $display("FAIL instr: got %h@%h required %h@%h", bus.instr, bus.instr_pc, exp ^ 8'h5A, exp);
        end
        if (rdy_dly > 0) begin
            set_noise(1'b1);
            repeat (rdy_dly) @(negedge clk);
            set_noise(1'b0);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 ||
                bus.instr !== (exp ^ 8'h5A) || bus.instr_pc !== exp) begin
                failures++;
                $display("FAIL stall_hold: valid=%b req=%b instr=%h pc=%h required 1/0/%h/%h",
                         bus.instr_valid, bus.imem_req, bus.instr, bus.instr_pc, exp ^ 8'h5A, exp);
            end
        end
        bus.instr_ready = 1'b1;
        bus.jmp_valid   = j;
        bus.call_valid  = c;
        bus.ret_valid   = r;
        bus.jmp_target  = t;
        halt            = hlt;
        inc = exp + 8'd1;
        nxt = inc;
        if (hlt) begin
            nxt = exp;
        end else begin
`ifdef PC_CALL_STACK_EN
            if (r) begin
                if (mstk.size() == 0) merr = 1'b1;
                else                  nxt  = mstk.pop_back();
            end else if (c) begin
                nxt = t;
                if (mstk.size() == 4) merr = 1'b1;
                else                  mstk.push_back(inc);
            end else if (j) begin
                nxt = t;
            end
`else
            if (j || c) nxt = t;
`endif
        end
        exp_q.push_back(nxt);
        held = bus.instr_pc;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        halt            = 1'b0;
        set_noise(1'b0);
        checks++;
        if (hlt) begin
            if (bus.instr_valid !== 1'b0 || running !== 1'b0 || bus.imem_addr !== held) begin
                failures++;
                $display("FAIL halt_in_hold: valid=%b running=%b addr=%h required 0/0/%h",
                         bus.instr_valid, running, bus.imem_addr, held);
            end
        end else if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL next_req: valid=%b req=%b required 0/1", bus.instr_valid, bus.imem_req);
        end
        checks++;
        if (stk_err !== merr) begin
            failures++;
            $display("FAIL stk_err: got %b required %b", stk_err, merr);
        end
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        checks++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || running !== 1'b0 || stk_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: req=%b valid=%b running=%b err=%b required 0/0/0/0",
                     bus.imem_req, bus.instr_valid, running, stk_err);
        end
        checks++;
        if (bus.instr !== 8'h00 || bus.instr_pc !== 8'h00 || bus.imem_addr !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: instr=%h instr_pc=%h addr=%h required 00/00/00",
                     bus.instr, bus.instr_pc, bus.imem_addr);
        end
        halt = 1'b1;
        start_pulse();
        halt = 1'b0;
        @(negedge clk);
        checks++;
        if (running !== 1'b0) begin
            failures++;
            $display("FAIL start_with_halt: running=%b required 0", running);
        end
        start_pulse();
        n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.imem_req !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_fetch: req=%b running=%b required 0/0", bus.imem_req, running);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        start_pulse();
        exp_q.push_back(8'h00);
        serve_one(1, 0, 0, 0, 0, 8'h00, 0);
        serve_one(1, 0, 0, 0, 0, 8'h00, 0);
        serve_one(0, 5, 0, 0, 0, 8'h00, 0);
        serve_one(1, 0, 0, 0, 0, 8'h00, 0);
        serve_one(2, 1, 0, 0, 0, 8'h00, 0);
    endtask

    task automatic test_wrap();
        do_reset();
        start_pulse();
        exp_q.push_back(8'h00);
        serve_one(0, 0, 1, 0, 0, 8'hFF, 0);
        serve_one(0, 0, 0, 0, 0, 8'h00, 0);
        serve_one(0, 0, 0, 0, 0, 8'h00, 0);
    endtask

    task automatic test_jump();
        do_reset();
        start_pulse();
        exp_q.push_back(8'h00);
        serve_one(0, 0, 1, 0, 0, 8'h05, 0);
        serve_one(1, 3, 1, 0, 0, 8'h40, 0);
        serve_one(0, 2, 0, 0, 0, 8'h00, 0);
        serve_one(0, 0, 0, 0, 0, 8'h00, 0);
    endtask

    task automatic test_halt_fetch();
        int n;
        logic [7:0] exp;
        do_reset();
        start_pulse();
        exp_q.push_back(8'h00);
        serve_one(0, 0, 1, 0, 0, 8'h10, 0);
        n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        exp = exp_q.pop_front();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp) begin
            failures++;
            $display("FAIL halt_fetch_req: req=%b addr=%h required 1/%h", bus.imem_req, bus.imem_addr, exp);
        end
        halt = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL halt_fetch_outstanding: req=%b required 1", bus.imem_req);
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'hC3;
        @(negedge clk);
        bus.imem_ack  = 1'b0;
        halt = 1'b0;
        checks++;
        if (bus.instr_valid !== 1'b0 || running !== 1'b0 || bus.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL halt_fetch_state: valid=%b running=%b req=%b required 0/0/0",
                     bus.instr_valid, running, bus.imem_req);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (running !== 1'b0 || bus.imem_addr !== exp) begin
            failures++;
            $display("FAIL halted_hold: running=%b addr=%h required 0/%h", running, bus.imem_addr, exp);
        end
        start_pulse();
        exp_q.push_back(exp);
        serve_one(0, 0, 0, 0, 0, 8'h00, 0);
    endtask

    task automatic test_halt_hold();
        do_reset();
        start_pulse();
        exp_q.push_back(8'h00);
        serve_one(0, 0, 0, 0, 0, 8'h00, 0);
        serve_one(0, 1, 1, 0, 0, 8'h33, 1);
        repeat (2) @(negedge clk);
        start_pulse();
        serve_one(0, 0, 0, 0, 0, 8'h00, 0);
        serve_one(0, 0, 0, 0, 0, 8'h00, 0);
    endtask

    task automatic test_call_ret();
        do_reset();
        start_pulse();
        exp_q.push_back(8'h00);
        repeat (3) serve_one(0, 0, 0, 0, 0, 8'h00, 0);
        serve_one(0, 0, 0, 1, 0, 8'h20, 0);
        serve_one(0, 0, 0, 0, 0, 8'h00, 0);
        serve_one(0, 0, 0, 1, 0, 8'h30, 0);
        serve_one(0, 0, 0, 0, 1, 8'h00, 0);
        serve_one(1, 0, 0, 0, 1, 8'h00, 0);
        serve_one(0, 0, 0, 1, 0, 8'h50, 0);
        serve_one(0, 0, 0, 1, 0, 8'h60, 0);
        serve_one(0, 0, 0, 1, 0, 8'h70, 0);
        serve_one(0, 0, 0, 1, 0, 8'h80, 0);
        serve_one(0, 0, 0, 1, 0, 8'h90, 0);
        repeat (5) serve_one(0, 0, 0, 0, 1, 8'h00, 0);
        serve_one(0, 0, 0, 1, 0, 8'hA0, 0);
        serve_one(0, 0, 0, 1, 1, 8'hB0, 0);
        serve_one(0, 0, 0, 0, 0, 8'h00, 0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_jump();
        test_halt_fetch();
        test_halt_hold();
        test_call_ret();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
